// File: rtl/plate_box_extract.sv
// Bounding-box extractor for the binarised pixel stream; publishes one box per frame at frame end.
// Optional BOX_MARGIN_EN widens the published box by MARGIN pixels, clamped to the display.
module plate_box_extract #(
    parameter int H_DISP  = 640,
    parameter int V_DISP  = 480,
    parameter int ROW_MIN = 4,
    parameter int MARGIN  = 2
) (
    input  logic       lcd_clk,
    input  logic       sys_rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_bit,
    output logic [9:0] left_pos,
    output logic [9:0] right_pos,
    output logic [9:0] up_pos,
    output logic [9:0] down_pos,
    output logic       box_found,
    output logic       box_valid
);
    localparam int CW = $clog2(H_DISP + 1);
    localparam logic [9:0]    X_MAX   = 10'(H_DISP - 1);
    localparam logic [9:0]    Y_MAX   = 10'(V_DISP - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(H_DISP);
    localparam logic [CW-1:0] CNT_MIN = CW'(ROW_MIN);

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] CLOSE    = 2'd2;
    localparam logic [1:0] PUBLISH  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          vsync_q, href_q;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [9:0]    row_min_q, row_min_d, row_max_q, row_max_d;
    logic          found_q, found_d;
    logic [9:0]    fl_q, fl_d, fr_q, fr_d, fu_q, fu_d, fd_q, fd_d;
    logic [9:0]    left_q, left_d, right_q, right_d, up_q, up_d, down_q, down_d;
    logic          box_found_q, box_found_d, box_valid_q, box_valid_d;
    logic [9:0]    pub_l, pub_r, pub_u, pub_d;

    logic vs_rise, vs_fall, hr_fall, pix, row_close;
    assign vs_rise   = per_frame_vsync & ~vsync_q;
    assign vs_fall   = ~per_frame_vsync & vsync_q;
    assign hr_fall   = ~per_frame_href & href_q;
    assign pix       = per_frame_href & per_frame_clken;
    // A row still open when vsync drops is closed in CLOSE so the last line counts.
    assign row_close = ((state_q == ACTIVE) && hr_fall) || ((state_q == CLOSE) && href_q);

    always_comb begin
`ifdef BOX_MARGIN_EN
        logic [10:0] r_ext, d_ext;
        r_ext = {1'b0, fr_q} + 11'(MARGIN);
        d_ext = {1'b0, fd_q} + 11'(MARGIN);
        pub_l = (fl_q >= 10'(MARGIN)) ? fl_q - 10'(MARGIN) : '0;
        pub_u = (fu_q >= 10'(MARGIN)) ? fu_q - 10'(MARGIN) : '0;
        pub_r = (r_ext > {1'b0, X_MAX}) ? X_MAX : r_ext[9:0];
        pub_d = (d_ext > {1'b0, Y_MAX}) ? Y_MAX : d_ext[9:0];
`else
        pub_l = fl_q;
        pub_r = fr_q;
        pub_u = fu_q;
        pub_d = fd_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        row_cnt_d   = row_cnt_q;
        row_min_d   = row_min_q;
        row_max_d   = row_max_q;
        found_d     = found_q;
        fl_d        = fl_q;
        fr_d        = fr_q;
        fu_d        = fu_q;
        fd_d        = fd_q;
        left_d      = left_q;
        right_d     = right_q;
        up_d        = up_q;
        down_d      = down_q;
        box_found_d = box_found_q;
        box_valid_d = 1'b0;

        case (state_q)
            WAIT_SOF: if (vs_rise) begin
                state_d   = ACTIVE;
                x_d       = '0;
                y_d       = '0;
                row_cnt_d = '0;
                row_min_d = X_MAX;
                row_max_d = '0;
                found_d   = 1'b0;
                fl_d      = X_MAX;
                fr_d      = '0;
                fu_d      = '0;
                fd_d      = '0;
            end
            ACTIVE: begin
                if (pix) begin
                    if (per_img_bit) begin
                        if (row_cnt_q != CNT_MAX) row_cnt_d = row_cnt_q + 1'b1;
                        if (x_q < row_min_q) row_min_d = x_q;
                        if (x_q > row_max_q) row_max_d = x_q;
                    end
                    if (x_q != X_MAX) x_d = x_q + 1'b1;
                end
                if (vs_fall) state_d = CLOSE;
            end
            CLOSE: state_d = PUBLISH;
            default: begin
                state_d     = WAIT_SOF;
                box_valid_d = 1'b1;
                box_found_d = found_q;
                left_d      = found_q ? pub_l : '0;
                right_d     = found_q ? pub_r : '0;
                up_d        = found_q ? pub_u : '0;
                down_d      = found_q ? pub_d : '0;
            end
        endcase

        if (row_close) begin
            if (row_cnt_q >= CNT_MIN) begin
                if (row_min_q < fl_q) fl_d = row_min_q;
                if (row_max_q > fr_q) fr_d = row_max_q;
                if (!found_q) fu_d = y_q;
                fd_d    = y_q;
                found_d = 1'b1;
            end
            row_cnt_d = '0;
            row_min_d = X_MAX;
            row_max_d = '0;
            x_d       = '0;
            if (y_q != Y_MAX) y_d = y_q + 1'b1;
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= WAIT_SOF;
            // Treat vsync as already high so a frame in flight at release is not seen as a rise.
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            row_cnt_q   <= '0;
            row_min_q   <= X_MAX;
            row_max_q   <= '0;
            found_q     <= 1'b0;
            fl_q        <= X_MAX;
            fr_q        <= '0;
            fu_q        <= '0;
            fd_q        <= '0;
            left_q      <= '0;
            right_q     <= '0;
            up_q        <= '0;
            down_q      <= '0;
            box_found_q <= 1'b0;
            box_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= per_frame_vsync;
            href_q      <= per_frame_href;
            x_q         <= x_d;
            y_q         <= y_d;
            row_cnt_q   <= row_cnt_d;
            row_min_q   <= row_min_d;
            row_max_q   <= row_max_d;
            found_q     <= found_d;
            fl_q        <= fl_d;
            fr_q        <= fr_d;
            fu_q        <= fu_d;
            fd_q        <= fd_d;
            left_q      <= left_d;
            right_q     <= right_d;
            up_q        <= up_d;
            down_q      <= down_d;
            box_found_q <= box_found_d;
            box_valid_q <= box_valid_d;
        end
    end

    assign left_pos  = left_q;
    assign right_pos = right_q;
    assign up_pos    = up_q;
    assign down_pos  = down_q;
    assign box_found = box_found_q;
    assign box_valid = box_valid_q;
endmodule

// File: tb/tb_plate_box_extract.sv
// Directed bench for plate_box_extract: frames built from per-row foreground spans.
// Expected boxes are hand-written for both the default and the BOX_MARGIN_EN build.
module tb_plate_box_extract;
    logic       lcd_clk = 1'b0;
    logic       sys_rst_n, vs, hr, ce, bit_i;
    logic [9:0] lp, rp, up, dp;
    logic       bf, bv;

    int n_run  = 0;
    int n_fail = 0;
    int pulses = 0;
    int glitches = 0;
    logic [40:0] prev_out = '0;
    int rn[480], rl[480], rh[480];

    always #5 lcd_clk = ~lcd_clk;

    plate_box_extract dut (
        .lcd_clk        (lcd_clk),
        .sys_rst_n      (sys_rst_n),
        .per_frame_vsync(vs),
        .per_frame_href (hr),
        .per_frame_clken(ce),
        .per_img_bit    (bit_i),
        .left_pos       (lp),
        .right_pos      (rp),
        .up_pos         (up),
        .down_pos       (dp),
        .box_found      (bf),
        .box_valid      (bv)
    );

    // Outputs may only move together with a box_valid pulse.
    always @(negedge lcd_clk) begin
        if (bv) pulses++;
        if (sys_rst_n && !bv && {lp, rp, up, dp, bf} != prev_out) glitches++;
        prev_out = {lp, rp, up, dp, bf};
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_rows();
        for (int i = 0; i < 480; i++) begin
            rn[i] = 1; rl[i] = 1; rh[i] = 0;
        end
    endtask

    task automatic set_rows(input int y0, input int y1, input int n, input int lo, input int hi);
        for (int y = y0; y <= y1; y++) begin
            rn[y] = n; rl[y] = lo; rh[y] = hi;
        end
    endtask

    task automatic send_line(input int n, input int lo, input int hi, input bit tail);
        for (int i = 0; i < n; i++) begin
            if (i % 13 == 5) begin
                @(negedge lcd_clk); hr = 1'b1; ce = 1'b0; bit_i = 1'b1;
            end
            @(negedge lcd_clk); hr = 1'b1; ce = 1'b1; bit_i = (i >= lo && i <= hi);
        end
        if (tail) begin
            @(negedge lcd_clk); hr = 1'b0; ce = 1'b0; bit_i = 1'b0;
            @(negedge lcd_clk);
        end
    endtask

    task automatic run_frame(input string tag, input bit hold, input int el, input int er,
                             input int eu, input int ed, input int ef);
        int p0, g0, lat;
        @(negedge lcd_clk); vs = 1'b1;
        repeat (3) @(negedge lcd_clk);
        g0 = glitches;
        p0 = pulses;
        for (int y = 0; y < 480; y++) send_line(rn[y], rl[y], rh[y], !(hold && y == 479));
        @(negedge lcd_clk); vs = 1'b0; ce = 1'b0; bit_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge lcd_clk); hr = 1'b0;
            if (bv) lat = k;
        end
        chk({tag, ".latency"}, lat, 3);
        chk({tag, ".left"}, int'(lp), el);
        chk({tag, ".right"}, int'(rp), er);
        chk({tag, ".up"}, int'(up), eu);
        chk({tag, ".down"}, int'(dp), ed);
        chk({tag, ".found"}, int'(bf), ef);
        repeat (4) @(negedge lcd_clk);
        chk({tag, ".pulses"}, pulses - p0, 1);
        chk({tag, ".stable"}, glitches - g0, 0);
    endtask

    initial begin
        int p0;
        sys_rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ce = 1'b0; bit_i = 1'b0;
        repeat (3) @(negedge lcd_clk);
        chk("rst.left", int'(lp), 0);
        chk("rst.down", int'(dp), 0);
        chk("rst.found", int'(bf), 0);
        chk("rst.valid", int'(bv), 0);

        // Frame already running when reset releases must be ignored.
        p0 = pulses;
        vs = 1'b1;
        send_line(20, 0, 19, 1'b1);
        sys_rst_n = 1'b1;
        repeat (3) send_line(20, 0, 19, 1'b1);
        @(negedge lcd_clk); vs = 1'b0;
        repeat (10) @(negedge lcd_clk);
        chk("rel.pulses", pulses - p0, 0);
        chk("rel.found", int'(bf), 0);
        chk("rel.right", int'(rp), 0);

        clear_rows();
        set_rows(300, 319, 300, 200, 299);
`ifdef BOX_MARGIN_EN
        run_frame("t1", 1'b0, 198, 301, 298, 321, 1);
`else
        run_frame("t1", 1'b0, 200, 299, 300, 319, 1);
`endif

        clear_rows();
        run_frame("t2", 1'b0, 0, 0, 0, 0, 0);

        clear_rows();
        set_rows(50, 50, 8, 5, 7);
        set_rows(60, 61, 20, 10, 19);
`ifdef BOX_MARGIN_EN
        run_frame("t3", 1'b0, 8, 21, 58, 63, 1);
`else
        run_frame("t3", 1'b0, 10, 19, 60, 61, 1);
`endif

        // Corner rows with exactly ROW_MIN pixels; last line still open when vsync drops.
        clear_rows();
        set_rows(0, 0, 640, 0, 3);
        set_rows(479, 479, 640, 636, 639);
        run_frame("t4", 1'b1, 0, 639, 0, 479, 1);

        clear_rows();
        set_rows(100, 101, 300, 200, 299);
`ifdef BOX_MARGIN_EN
        run_frame("t5", 1'b0, 198, 301, 98, 103, 1);
`else
        run_frame("t5", 1'b0, 200, 299, 100, 101, 1);
`endif

        // Reset asserted and released inside a frame.
        p0 = pulses;
        @(negedge lcd_clk); vs = 1'b1;
        repeat (2) send_line(20, 0, 19, 1'b1);
        sys_rst_n = 1'b0;
        @(negedge lcd_clk);
        chk("t6.rst_left", int'(lp), 0);
        chk("t6.rst_found", int'(bf), 0);
        send_line(20, 0, 19, 1'b1);
        sys_rst_n = 1'b1;
        repeat (3) send_line(20, 0, 19, 1'b1);
        @(negedge lcd_clk); vs = 1'b0;
        repeat (10) @(negedge lcd_clk);
        chk("t6.pulses", pulses - p0, 0);
        chk("t6.up", int'(up), 0);
        chk("t6.found", int'(bf), 0);

        clear_rows();
        set_rows(300, 319, 300, 200, 299);
`ifdef BOX_MARGIN_EN
        run_frame("t6b", 1'b0, 198, 301, 298, 321, 1);
`else
        run_frame("t6b", 1'b0, 200, 299, 300, 319, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
